// File: rtl/tc_file_rom_reader_pkg.sv
// Shared types and constants for the file-backed ROM reader.
package tc_file_rom_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSize,
    StFetch,
    StDrain,
    StDone
  } state_e;

  localparam logic [63:0] ROM_SIZE_ADDR = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int unsigned WORD_BYTES    = 8;

endpackage

// File: rtl/tc_word_unpacker.sv
// Holds one 64-bit ROM word and presents it a byte at a time, little-endian.
module tc_word_unpacker
  import tc_file_rom_reader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [63:0] i_word,
  input  logic [3:0]  i_cnt,
  output logic [7:0]  o_byte,
  output logic        o_idx_last
);

  logic [63:0] r_buf;
  logic [2:0]  r_idx;
  logic [3:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_buf <= '0;
      r_idx <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_buf <= i_word;
      r_idx <= '0;
      r_cnt <= i_cnt;
    end else if (i_advance) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  assign o_byte     = r_buf[{r_idx, 3'b000} +: 8];
  assign o_idx_last = ({1'b0, r_idx} == (r_cnt - 4'd1));

endmodule

// File: rtl/tc_file_rom_reader.sv
// Reads the file size from the ROM, then streams the file out one byte per handshake.
module tc_file_rom_reader
  import tc_file_rom_reader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [63:0] MAX_BYTES = 64'd302
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_rom_en,
  output logic [63:0] o_rom_address,
  input  logic [63:0] i_rom_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_out_byte,
  output logic        o_out_last,
  output logic [63:0] o_total_bytes,
  output logic        o_busy,
  output logic        o_done
);

  state_e      r_state, w_state_d;
  logic        r_rom_en, w_rom_en_d;
  logic [63:0] r_rom_address, w_rom_address_d;
  logic [63:0] r_ptr, w_ptr_d;
  logic [63:0] r_len, w_len_d;
  logic [63:0] r_total, w_total_d;

  logic [63:0] w_clamped;
  logic [63:0] w_remain;
  logic [3:0]  w_cnt;
  logic        w_load;
  logic        w_advance;
  logic        w_last;
  logic        w_idx_last;
  logic [7:0]  w_byte;

  assign w_clamped = (i_rom_data > MAX_BYTES) ? MAX_BYTES : i_rom_data;
  assign w_remain  = r_len - r_ptr;
  assign w_cnt     = (w_remain >= 64'(WORD_BYTES)) ? 4'(WORD_BYTES) : 4'(w_remain);
  assign w_last    = (r_state == StDrain) && (r_ptr == r_len - 64'd1);

  tc_word_unpacker u_unpacker (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_advance  (w_advance),
    .i_word     (i_rom_data),
    .i_cnt      (w_cnt),
    .o_byte     (w_byte),
    .o_idx_last (w_idx_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= StIdle;
      r_rom_en      <= 1'b0;
      r_rom_address <= '0;
      r_ptr         <= '0;
      r_len         <= '0;
      r_total       <= '0;
    end else begin
      r_state       <= w_state_d;
      r_rom_en      <= w_rom_en_d;
      r_rom_address <= w_rom_address_d;
      r_ptr         <= w_ptr_d;
      r_len         <= w_len_d;
      r_total       <= w_total_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_rom_en_d      = r_rom_en;
    w_rom_address_d = r_rom_address;
    w_ptr_d         = r_ptr;
    w_len_d         = r_len;
    w_total_d       = r_total;
    w_load          = 1'b0;
    w_advance       = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d       = StSize;
          w_rom_en_d      = 1'b1;
          w_rom_address_d = ROM_SIZE_ADDR;
        end
      end
      StSize: begin
        w_len_d   = w_clamped;
        w_total_d = w_clamped;
        if (w_clamped == 64'd0) begin
          w_state_d  = StDone;
          w_rom_en_d = 1'b0;
        end else begin
          w_state_d       = StFetch;
          w_ptr_d         = '0;
          w_rom_address_d = BASE_ADDR;
        end
      end
      StFetch: begin
        w_load     = 1'b1;
        w_rom_en_d = 1'b0;
        w_state_d  = StDrain;
      end
      StDrain: begin
        // out_valid is constant high here, so ready alone completes the handshake
        if (i_out_ready) begin
          w_advance = 1'b1;
          w_ptr_d   = r_ptr + 64'd1;
          if (w_last) begin
            w_state_d = StDone;
          end else if (w_idx_last) begin
            w_state_d       = StFetch;
            w_rom_en_d      = 1'b1;
            w_rom_address_d = BASE_ADDR + r_ptr + 64'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_rom_en      = r_rom_en;
  assign o_rom_address = r_rom_address;
  assign o_out_valid   = (r_state == StDrain);
  assign o_out_byte    = w_byte;
  assign o_out_last    = w_last;
  assign o_total_bytes = r_total;
  assign o_busy        = (r_state == StSize) || (r_state == StFetch) || (r_state == StDrain);
  assign o_done        = (r_state == StDone);

endmodule

// File: tb/tb_tc_file_rom_reader.sv
// Randomised bench: a byte-array ROM model and an expected byte stream built from it.
module tb_tc_file_rom_reader;

  localparam logic [63:0] MaxBytes = 64'd302;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rom_en;
  logic [63:0] rom_address;
  logic [63:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [63:0] total_bytes;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:1023];
  logic [63:0] file_size;

  int n_vec = 0;
  int n_err = 0;

  tc_file_rom_reader dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_rom_en      (rom_en),
    .o_rom_address (rom_address),
    .i_rom_data    (rom_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_byte    (out_byte),
    .o_out_last    (out_last),
    .o_total_bytes (total_bytes),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // Combinational ROM: size at all-ones, otherwise 8 little-endian bytes.
  always_comb begin
    rom_data = '0;
    if (rom_address == 64'hFFFF_FFFF_FFFF_FFFF) begin
      rom_data = file_size;
    end else begin
      for (int k = 0; k < 8; k++) rom_data[8*k +: 8] = mem[10'(rom_address + 64'(k))];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rom_en"}, 64'(rom_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_addr"}, rom_address, 64'd0);
    check({tag, "_total"}, total_bytes, 64'd0);
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
  // rst_at: index of the presented byte at which reset is asserted (-1 for none).
  task automatic run(input logic [63:0] size, input int mode, input int rst_at,
                     input bit pulse_start);
    logic [63:0] len;
    int          n;
    int          c;
    int          pat;
    int          first_valid;
    int          fetches;
    bit          prev_stall;
    logic [7:0]  prev_byte;
    bit          finished;
    len         = (size > MaxBytes) ? MaxBytes : size;
    file_size   = size;
    n           = 0;
    pat         = 0;
    first_valid = -1;
    fetches     = 0;
    prev_stall  = 1'b0;
    prev_byte   = '0;
    finished    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < 5000) begin
      if (c == 1) begin
        check("size_en", 64'(rom_en), 64'd1);
        check("size_addr", rom_address, 64'hFFFF_FFFF_FFFF_FFFF);
      end else if (rom_en) begin
        check("fetch_addr", rom_address, 64'(fetches) * 64'd8);
        fetches++;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (prev_stall) check("stall_hold", 64'(out_byte), 64'(prev_byte));
        check("byte", 64'(out_byte), 64'(mem[n]));
        check("last", 64'(out_last), 64'(64'(n) == len - 64'd1));
        if (n == rst_at) begin
          rst       = 1'b0;
          out_ready = 1'b1;
          @(negedge clk);
          rst = 1'b1;
          check_reset_state("midrst");
          return;
        end
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (pat % 4 == 0) || (pat % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pat++;
      start      = pulse_start && out_valid && (n == 2);
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      if (out_valid && out_ready) n++;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("finished", 64'(finished), 64'd1);
    check("done_valid_low", 64'(out_valid), 64'd0);
    check("byte_count", 64'(n), len);
    check("total_bytes", total_bytes, len);
    check("fetch_count", 64'(fetches), (len + 64'd7) / 64'd8);
    if (len == 64'd0) check("zero_done_cycle", 64'(c), 64'd2);
    else if (mode == 0) check("first_valid", 64'(first_valid), 64'd3);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    file_size = '0;
    fill_random();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check("reset_byte", 64'(out_byte), 64'd0);
    check("reset_last", 64'(out_last), 64'd0);
    rst = 1'b1;

    // 3-byte file
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    run(64'd3, 0, -1, 1'b0);
    check("done_3", 64'(done), 64'd1);

    // 20-byte counting file
    for (int i = 0; i < 20; i++) mem[i] = 8'(i);
    run(64'd20, 0, -1, 1'b0);

    // size clamp
    fill_random();
    run(64'd1000, 0, -1, 1'b0);

    // empty file
    run(64'd0, 0, -1, 1'b0);
    check("done_0", 64'(done), 64'd1);

    // stalled consumer with start pulse during drain
    run(64'd10, 1, -1, 1'b1);

    // reset at the 5th byte, then replay
    run(64'd10, 0, 4, 1'b0);
    run(64'd10, 0, -1, 1'b0);

    // random sizes and random ready
    for (int t = 0; t < 8; t++) begin
      fill_random();
      run(64'($urandom_range(0, 40)), 2, -1, ($urandom_range(0, 1) == 1));
    end
    run(64'($urandom_range(303, 5000)), 2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
